// File: rtl/mem_port_arbiter_if.sv
// Bundles the I-side, D-side and backing-memory signals of the shared memory port arbiter.
// The arbiter uses the slave modport; the requester/memory environment uses master.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [DATA_W-1:0] i_rdata;

   logic              d_req;
   logic              d_wen;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [3:0]        d_bsel;
   logic              d_ack;
   logic [DATA_W-1:0] d_rdata;

   logic              mem_ren;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [3:0]        mem_bsel;
   logic [DATA_W-1:0] mem_rdata;

   logic              busy;

   modport slave (
      input  i_req, i_addr, d_req, d_wen, d_addr, d_wdata, d_bsel, mem_rdata,
      output i_ack, i_rdata, d_ack, d_rdata, mem_ren, mem_wen, mem_addr, mem_wdata, mem_bsel, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_wen, d_addr, d_wdata, d_bsel, mem_rdata,
      input  i_ack, i_rdata, d_ack, d_rdata, mem_ren, mem_wen, mem_addr, mem_wdata, mem_bsel, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory between the I-side and D-side MMUs.
// Each transaction runs IDLE -> ACCESS (MEM_LATENCY cycles) -> RESPOND (one-cycle ack).
module mem_port_arbiter #(
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MEM_LATENCY = 2,
   parameter int CNT_W       = 4
) (
   input  logic              clk,
   input  logic              reset,
   mem_port_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ACCESS  = 2'd1,
      RESPOND = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);
   localparam logic             OWNER_I  = 1'b0;
   localparam logic             OWNER_D  = 1'b1;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              owner_q, owner_d;
   logic              last_grant_q, last_grant_d;
   logic              wen_q, wen_d;
   logic              load;
   logic              capture;
   logic              grant_dside;

   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [3:0]        bsel_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

   // D wins when it is alone, or on a tie when I had the previous grant.
   assign grant_dside = bus.d_req && (!bus.i_req || (last_grant_q == OWNER_I));

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      wen_d        = wen_q;
      load         = 1'b0;
      capture      = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.i_req || bus.d_req) begin
               owner_d      = grant_dside;
               last_grant_d = grant_dside;
               wen_d        = grant_dside && bus.d_wen;
               cnt_d        = CNT_INIT;
               load         = 1'b1;
               state_d      = ACCESS;
            end
         end
         ACCESS: begin
            if (cnt_q == '0) begin
               capture = 1'b1;
               state_d = RESPOND;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RESPOND: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         owner_q      <= OWNER_I;
         last_grant_q <= OWNER_D;
         wen_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         wen_q        <= wen_d;
      end
   end

   // Grant boundary: request payload captured once, later input changes are ignored.
   always_ff @(posedge clk) begin
      if (load) begin
         addr_q  <= grant_dside ? bus.d_addr  : bus.i_addr;
         wdata_q <= grant_dside ? bus.d_wdata : '0;
         bsel_q  <= grant_dside ? bus.d_bsel  : 4'b1111;
      end
   end

   // Access boundary: read data lands in the owner's register on the last access cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else if (capture && !wen_q) begin
         if (owner_q == OWNER_D) begin
            d_rdata_q <= bus.mem_rdata;
         end else begin
            i_rdata_q <= bus.mem_rdata;
         end
      end
   end

   // Memory-side outputs are gated by state so reset forces them low asynchronously.
   assign bus.mem_ren   = (state_q == ACCESS) && !wen_q;
   assign bus.mem_wen   = (state_q == ACCESS) &&  wen_q;
   assign bus.mem_addr  = (state_q == ACCESS) ? addr_q  : '0;
   assign bus.mem_wdata = (state_q == ACCESS) ? wdata_q : '0;
   assign bus.mem_bsel  = (state_q == ACCESS) ? bsel_q  : 4'b0000;

   assign bus.i_ack   = (state_q == RESPOND) && (owner_q == OWNER_I);
   assign bus.d_ack   = (state_q == RESPOND) && (owner_q == OWNER_D);
   assign bus.i_rdata = i_rdata_q;
   assign bus.d_rdata = d_rdata_q;
   assign bus.busy    = (state_q == ACCESS) || (state_q == RESPOND);

   property p_cnt_no_underflow;
      @(posedge clk) disable iff (!reset) (state_q == ACCESS) |-> (cnt_q <= CNT_INIT);
   endproperty
   a_cnt_no_underflow: assert property (p_cnt_no_underflow);

endmodule
